// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned word accesses.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Captured request payload
  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Datapath <-> data-memory request/response bundle.
interface dmem_responder_if;

  logic                          req_valid;
  logic                          req_ready;
  logic                          req_we;
  logic [dmem_pkg::WORD_W-1:0]   req_addr;
  logic [dmem_pkg::WORD_W-1:0]   req_wdata;
  logic                          rsp_valid;
  logic [dmem_pkg::WORD_W-1:0]   rsp_rdata;
  logic                          rsp_err;
  logic                          busy;

  // Datapath side
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  // Memory side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/dmem_array.sv
// Word-organised RAM: synchronous write, registered read.
// rdata is zero except in the cycle after an enabled read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              reset_,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] rdata_d;

  // Read data presented only for an enabled load
  always_comb begin
    rdata_d = '0;
    if (en && !we) rdata_d = mem[idx];
  end

  // Storage array write port (contents not reset)
  always_ff @(posedge clock) begin
    if (en && we) mem[idx] <= wdata;
  end

  // Read data register
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, fixed wait states, one-cycle response.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag req_addr[1:0] != 0 as an error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset_,
  dmem_responder_if.slave    bus
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_req_t        req_q, req_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;

  dmem_req_t        cur_req_c;
  logic             range_err_c;
  logic             align_err_c;
  logic             acc_err_c;
  logic             enter_resp_c;
  logic             ram_en_c;
  logic [WORD_W-1:0] ram_rdata;

  // Live request in IDLE (zero-wait path accesses RAM on the accept edge), captured otherwise
  always_comb begin
    if (state_q == IDLE) cur_req_c = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
    else                 cur_req_c = req_q;
  end

  // Access checks on the request being committed
  assign range_err_c = |cur_req_c.addr[WORD_W-1:AW+2];
`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err_c = |cur_req_c.addr[1:0];
`else
  logic unused_addr_lsb_c;
  assign unused_addr_lsb_c = ^cur_req_c.addr[1:0];
  assign align_err_c       = 1'b0;
`endif
  assign acc_err_c = range_err_c || align_err_c;

  // Next-state, counter, capture and response logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = RSP_OK;
    enter_resp_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          req_d = cur_req_c;
          if (WAIT_CYCLES == 0) begin
            state_d      = RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_resp_c) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err_c ? RSP_ERR : RSP_OK;
    end
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= RSP_OK;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  // RAM committed on the edge entering RESP, rejected accesses never reach it
  assign ram_en_c = enter_resp_c && !acc_err_c;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clock  (clock),
    .reset_ (reset_),
    .en     (ram_en_c),
    .we     (cur_req_c.we),
    .idx    (cur_req_c.addr[AW+1:2]),
    .wdata  (cur_req_c.wdata),
    .rdata  (ram_rdata)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = ram_rdata;
  assign bus.busy      = busy_q;

endmodule
